im_arbiter: RTL and testbench
=============================

IM_ARBITER -- requirements
Module: im_arbiter

Interface
- REQ-001 SHALL have parameters: DATA_W 32, data width; ADDR_W 12, byte address width; WAIT_STATE 2, memory wait states; BURST_LEN 16, words per read burst; TIMEOUT 8, max cycles from issue to first IM_ready.
- REQ-002 SHALL have ports:
  - clock  in  1  sole clock, rising edge.
  - reset  in  1  synchronous, active-low.
  - f_req  in  1  fetch port read request, level.
  - f_addr  in  ADDR_W  fetch byte address.
  - f_grant  out  1  fetch request accepted, 1-cycle pulse.
  - l_req  in  1  loader port request, level.
  - l_we  in  1  loader: 1 write, 0 read.
  - l_addr  in  ADDR_W  loader byte address.
  - l_wdata  in  DATA_W  loader write data.
  - l_grant  out  1  loader request accepted, 1-cycle pulse.
  - rd_valid_f / rd_valid_l  out  1 each  burst beat valid for fetch / loader.
  - rd_data  out  DATA_W  burst beat data.
  - rd_beat  out  4  beat index 0..BURST_LEN-1.
  - done_f / done_l  out  1 each  transaction complete, 1-cycle pulse.
  - err  out  1  asserted with done_* on timeout.
  - busy  out  1  state != IDLE.
  - IM_enable, IM_read, IM_write  out  1 each  memory strobes.
  - IM_address  out  ADDR_W  memory byte address.
  - IM_in  out  DATA_W  memory write data.
  - IM_out  in  DATA_W  memory read data.
  - IM_ready  in  1  memory beat valid.

Function
- REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT_R, BURST, WAIT_W; all outputs registered.
- REQ-004 IDLE: SHALL accept a request only when IM_ready==0; otherwise remain in IDLE.
- REQ-005 Arbitration: one requester -> that one; both -> round-robin, the port not granted last wins; after reset the loader wins first.
- REQ-006 On accept SHALL pulse the winner's grant, capture address/we/wdata, enter ISSUE.
- REQ-007 ISSUE (exactly 1 cycle): IM_enable=1, IM_read=~we, IM_write=we; IM_address = captured address with bits [5:0] cleared for reads, unmodified for writes; IM_in = captured wdata. All strobes 0 in every other state.
- REQ-008 ISSUE -> WAIT_R for read, WAIT_W for write.
- REQ-009 WAIT_R: count cycles; first IM_ready=1 -> BURST with beat 0 captured; count reaching TIMEOUT with no IM_ready -> done_<owner>=1, err=1, -> IDLE.
- REQ-010 BURST: each cycle IM_ready=1 SHALL drive rd_data=IM_out, rd_beat=beat count, rd_valid_<owner>=1 one cycle later; the non-owner valid stays 0.
- REQ-011 After beat BURST_LEN-1 SHALL pulse done_<owner> in the same cycle as its valid, -> IDLE; IM_ready=0 inside a burst SHALL end it early with done and err=1.
- REQ-012 WAIT_W: hold WAIT_STATE+1 cycles (memory commit latency), then pulse done_l, -> IDLE.
- REQ-013 Requests dropped after grant SHALL NOT abort the transaction; requests changing while busy SHALL be ignored.
- REQ-014 Beat counter SHALL be 4 bits and wrap from BURST_LEN-1 to 0; it never exceeds BURST_LEN-1 in BURST.
- REQ-015 A fetch request held across done SHALL be re-arbitrated in the next IDLE cycle, no bubble beyond the IM_ready==0 check.

Reset
- REQ-016 reset==0 at a rising edge SHALL force IDLE; all outputs 0; round-robin pointer to loader-first; counters 0.
- REQ-017 Reset mid-transaction SHALL abandon it with no done pulse; memory beats arriving after reset SHALL be ignored until the next ISSUE.

Verification
- REQ-018 Fetch f_addr=0x104, WAIT_STATE=2 -> f_grant; IM_address=0x100 for one cycle; 16 rd_valid_f beats, rd_beat 0..15; done_f on beat 15; err=0.
- REQ-019 Loader write l_addr=0x020, l_wdata=0xDEADBEEF -> IM_write one cycle; done_l 3 cycles after ISSUE; subsequent fetch of 0x000 returns 0xDEADBEEF on beat 8.
- REQ-020 f_req and l_req both high from reset -> loader first, fetch second, loader third; grants never overlap.
- REQ-021 Memory model never asserts IM_ready -> done_f and err=1 exactly 8 cycles after ISSUE; back to IDLE.
- REQ-022 reset=0 during BURST beat 5 -> all outputs 0 next cycle, no done_*; new fetch after release completes normally.

Source files
------------

// File: rtl/im_arbiter.sv
// im_arbiter: round-robin fetch/loader arbiter for a burst-read, single-write instruction memory
module im_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 12,
  parameter int WAIT_STATE = 2,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_grant,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_grant,
  output logic              rd_valid_f,
  output logic              rd_valid_l,
  output logic [DATA_W-1:0] rd_data,
  output logic [3:0]        rd_beat,
  output logic              done_f,
  output logic              done_l,
  output logic              err,
  output logic              busy,
  output logic              IM_enable,
  output logic              IM_read,
  output logic              IM_write,
  output logic [ADDR_W-1:0] IM_address,
  output logic [DATA_W-1:0] IM_in,
  input  logic [DATA_W-1:0] IM_out,
  input  logic              IM_ready
);
  localparam int CW = $clog2(TIMEOUT + WAIT_STATE + 2);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(6'h3f);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_R, BURST, WAIT_W} state_t;
  state_t state;
  logic prio_f, own_f, pick_f, rd_sel, last_beat;
  logic [CW-1:0] cnt;
  logic [3:0] beat;
  logic [ADDR_W-1:0] sel_addr;
  assign pick_f    = f_req & (~l_req | prio_f);
  assign rd_sel    = pick_f | ~l_we;
  assign sel_addr  = pick_f ? f_addr : l_addr;
  assign last_beat = beat == 4'(BURST_LEN - 1);
  // cnt holds the number of cycles elapsed since the ISSUE cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      prio_f     <= 1'b0;
      own_f      <= 1'b0;
      cnt        <= '0;
      beat       <= '0;
      f_grant    <= 1'b0;
      l_grant    <= 1'b0;
      rd_valid_f <= 1'b0;
      rd_valid_l <= 1'b0;
      rd_data    <= '0;
      rd_beat    <= '0;
      done_f     <= 1'b0;
      done_l     <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      IM_enable  <= 1'b0;
      IM_read    <= 1'b0;
      IM_write   <= 1'b0;
      IM_address <= '0;
      IM_in      <= '0;
    end else begin
      f_grant    <= 1'b0;
      l_grant    <= 1'b0;
      rd_valid_f <= 1'b0;
      rd_valid_l <= 1'b0;
      done_f     <= 1'b0;
      done_l     <= 1'b0;
      err        <= 1'b0;
      IM_enable  <= 1'b0;
      IM_read    <= 1'b0;
      IM_write   <= 1'b0;
      IM_address <= '0;
      IM_in      <= '0;
      cnt        <= cnt + 1'b1;
      case (state)
        IDLE: if (!IM_ready && (f_req || l_req)) begin
          state      <= ISSUE;
          busy       <= 1'b1;
          own_f      <= pick_f;
          prio_f     <= ~pick_f;
          f_grant    <= pick_f;
          l_grant    <= ~pick_f;
          IM_enable  <= 1'b1;
          IM_read    <= rd_sel;
          IM_write   <= ~rd_sel;
          IM_address <= rd_sel ? sel_addr & LINE_MASK : sel_addr;
          IM_in      <= pick_f ? '0 : l_wdata;
        end
        ISSUE: begin
          state <= IM_write ? WAIT_W : WAIT_R;
          cnt   <= CW'(1);
          beat  <= '0;
        end
        WAIT_R, BURST: if (IM_ready) begin
          rd_data    <= IM_out;
          rd_beat    <= beat;
          rd_valid_f <= own_f;
          rd_valid_l <= ~own_f;
          beat       <= last_beat ? '0 : beat + 4'd1;
          state      <= last_beat ? IDLE : BURST;
          busy       <= ~last_beat;
          done_f     <= last_beat & own_f;
          done_l     <= last_beat & ~own_f;
        end else if (state == BURST || cnt == CW'(TIMEOUT - 1)) begin
          state  <= IDLE;
          busy   <= 1'b0;
          beat   <= '0;
          done_f <= own_f;
          done_l <= ~own_f;
          err    <= 1'b1;
        end
        WAIT_W: if (cnt >= CW'(WAIT_STATE)) begin
          state  <= IDLE;
          busy   <= 1'b0;
          done_l <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_im_arbiter.sv
// tb_im_arbiter: randomized transactions against a timeline model of the arbiter and a burst memory
module tb_im_arbiter;
  localparam int WS = 2, TO = 8, BL = 16;
  logic clock = 1'b0, reset;
  logic f_req, l_req, l_we, f_grant, l_grant, rd_valid_f, rd_valid_l;
  logic done_f, done_l, err, busy, IM_enable, IM_read, IM_write, IM_ready;
  logic [11:0] f_addr, l_addr, IM_address;
  logic [31:0] l_wdata, rd_data, IM_in, IM_out;
  logic [3:0] rd_beat;
  logic any_out;
  int n_chk = 0, n_err = 0, cyc = 0, mem_nb = BL;
  int n_fg, n_lg, n_ovl, n_en, n_vf, n_vl, n_df, n_dl, n_serr, g_cyc, en_cyc, d_cyc;
  logic [11:0] en_addr;
  logic en_rd, en_wr, d_err;
  logic [31:0] en_in;
  logic [31:0] vq[$];
  int bq[$], cq[$], gcq[$], dcq[$];
  bit gq[$];
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int r_nb;
  logic [9:0] r_b;

  im_arbiter #(.DATA_W(32), .ADDR_W(12), .WAIT_STATE(WS), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .f_req(f_req), .f_addr(f_addr), .f_grant(f_grant),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_grant(l_grant),
    .rd_valid_f(rd_valid_f), .rd_valid_l(rd_valid_l), .rd_data(rd_data), .rd_beat(rd_beat),
    .done_f(done_f), .done_l(done_l), .err(err), .busy(busy),
    .IM_enable(IM_enable), .IM_read(IM_read), .IM_write(IM_write),
    .IM_address(IM_address), .IM_in(IM_in), .IM_out(IM_out), .IM_ready(IM_ready)
  );

  assign any_out = |{f_grant, l_grant, rd_valid_f, rd_valid_l, rd_data, rd_beat, done_f, done_l,
                     err, busy, IM_enable, IM_read, IM_write, IM_address, IM_in};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_log();
    n_fg = 0; n_lg = 0; n_ovl = 0; n_en = 0; n_vf = 0; n_vl = 0; n_df = 0; n_dl = 0; n_serr = 0;
    g_cyc = -1; en_cyc = -1; d_cyc = -1; en_addr = '0; en_rd = 0; en_wr = 0; en_in = '0; d_err = 0;
    vq.delete(); bq.delete(); cq.delete(); gq.delete(); gcq.delete(); dcq.delete();
  endtask

  // Observation log sampled mid-cycle
  always @(negedge clock) begin
    if (f_grant) begin n_fg++; g_cyc = cyc; gq.push_back(1'b1); gcq.push_back(cyc); end
    if (l_grant) begin n_lg++; g_cyc = cyc; gq.push_back(1'b0); gcq.push_back(cyc); end
    if (f_grant && l_grant) n_ovl++;
    if (IM_enable) begin
      n_en++; en_cyc = cyc; en_addr = IM_address; en_rd = IM_read; en_wr = IM_write; en_in = IM_in;
    end
    if (rd_valid_f || rd_valid_l) begin
      vq.push_back(rd_data); bq.push_back(int'(rd_beat)); cq.push_back(cyc);
    end
    if (rd_valid_f) n_vf++;
    if (rd_valid_l) n_vl++;
    if (done_f) n_df++;
    if (done_l) n_dl++;
    if (done_f || done_l) begin d_cyc = cyc; d_err = err; dcq.push_back(cyc); end
    if (err && !(done_f || done_l)) n_serr++;
  end

  // Memory: commits writes on the strobe, answers reads after WS cycles with mem_nb beats
  initial begin
    IM_ready = 1'b0;
    IM_out = '0;
    forever begin
      @(posedge clock);
      #1;
      if (IM_enable && IM_write) mem[IM_address[11:2]] = IM_in;
      else if (IM_enable && IM_read && mem_nb > 0) begin
        r_nb = mem_nb;
        r_b = IM_address[11:2];
        repeat (WS + 1) @(posedge clock);
        #1;
        for (int i = 0; i < r_nb; i++) begin
          IM_ready = 1'b1;
          IM_out = mem[r_b + 10'(i)];
          @(posedge clock);
          #1;
        end
        IM_ready = 1'b0;
        IM_out = $urandom;
      end
    end
  end

  task automatic wait_idle();
    int i = 0;
    do begin @(negedge clock); i++; end while ((busy || IM_ready) && i < 60);
    check("idle_wait", busy || IM_ready, 0);
    @(posedge clock);
    #1;
  endtask

  // nb: BL = full burst, 1..BL-1 = memory stops early, 0 = memory never answers
  task automatic run_txn(input bit pf, input logic [11:0] a, input bit w, input logic [31:0] wd, input int nb);
    int t0, exp_done, nexp, base;
    bit rd;
    rd = pf || !w;
    wait_idle();
    clear_log();
    mem_nb = nb;
    if (pf) begin f_addr = a; f_req = 1; end
    else begin l_addr = a; l_we = w; l_wdata = wd; l_req = 1; end
    t0 = cyc + 1;
    for (int i = 0; i < 10 && n_fg + n_lg == 0; i++) @(negedge clock);
    check("grant_seen", n_fg + n_lg, 1);
    @(posedge clock);
    #1;
    f_req = 0; l_req = 0;
    f_addr = 12'($urandom); l_addr = 12'($urandom); l_we = 1'($urandom); l_wdata = $urandom;
    for (int i = 0; i < 80 && n_df + n_dl == 0; i++) @(negedge clock);
    repeat (2) @(negedge clock);
    if (!rd) ref_mem[a[11:2]] = wd;
    base = int'({a[11:6], 4'b0000});
    nexp = rd ? nb : 0;
    exp_done = !rd ? t0 + WS + 1 : nb == 0 ? t0 + TO : nb == BL ? t0 + WS + 1 + BL : t0 + WS + 2 + nb;
    check("grant_f", n_fg, pf);
    check("grant_l", n_lg, !pf);
    check("grant_cyc", g_cyc, t0);
    check("issue_cnt", n_en, 1);
    check("issue_cyc", en_cyc, t0);
    check("issue_addr", en_addr, rd ? (a & 12'hfc0) : a);
    check("issue_rd", en_rd, rd);
    check("issue_wr", en_wr, !rd);
    if (!rd) check("issue_wdata", en_in, wd);
    check("valid_f_cnt", n_vf, pf ? nexp : 0);
    check("valid_l_cnt", n_vl, pf ? 0 : nexp);
    for (int k = 0; k < vq.size() && k < nexp; k++) begin
      check("beat_data", vq[k], ref_mem[base + k]);
      check("beat_idx", bq[k], k);
      check("beat_cyc", cq[k], t0 + WS + 2 + k);
    end
    check("done_f_cnt", n_df, pf);
    check("done_l_cnt", n_dl, !pf);
    check("done_cyc", d_cyc, exp_done);
    check("done_err", d_err, rd && nb != BL);
    check("stray_err", n_serr, 0);
    check("idle_after", busy, 0);
  endtask

  initial begin
    int r, nb;
    bit p;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    // Both ports requesting straight out of reset
    reset = 0; f_req = 1; l_req = 1; l_we = 0; f_addr = 12'h040; l_addr = 12'h380; l_wdata = '0;
    repeat (3) @(negedge clock);
    check("rst_outs", any_out, 0);
    check("rst_busy", busy, 0);
    @(posedge clock);
    #1;
    clear_log();
    reset = 1;
    for (int i = 0; i < 200 && gq.size() < 3; i++) @(negedge clock);
    check("rr_grants", gq.size(), 3);
    @(posedge clock);
    #1;
    f_req = 0; l_req = 0;
    for (int i = 0; i < 80 && dcq.size() < 3; i++) @(negedge clock);
    p = 0;
    for (int k = 0; k < gq.size() && k < 3; k++) begin
      check("rr_order", gq[k], p);
      p = !p;
    end
    for (int k = 1; k < gcq.size() && k <= dcq.size() && k < 3; k++)
      check("rr_gap", gcq[k], dcq[k-1] + 1);
    check("rr_overlap", n_ovl, 0);
    check("rr_done_f", n_df, 1);
    check("rr_done_l", n_dl, 2);
    // Directed cases
    run_txn(1, 12'h104, 0, 0, BL);
    run_txn(0, 12'h020, 1, 32'hDEADBEEF, BL);
    run_txn(1, 12'h000, 0, 0, BL);
    check("wr_readback_b8", vq.size() > 8 ? vq[8] : 32'h0, 32'hDEADBEEF);
    run_txn(1, 12'h200, 0, 0, 0);
    run_txn(0, 12'h3c8, 0, 0, 5);
    run_txn(0, 12'h111, 0, 0, 0);
    // Reset in the middle of a burst
    wait_idle();
    clear_log();
    mem_nb = BL;
    f_addr = 12'h2c4; f_req = 1;
    for (int i = 0; i < 40 && !(rd_valid_f && rd_beat == 4'd5); i++) @(negedge clock);
    check("rst_beat5_seen", rd_valid_f && rd_beat == 4'd5, 1);
    reset = 0; f_req = 0;
    @(negedge clock);
    check("rst_mid_outs", any_out, 0);
    @(posedge clock);
    #1;
    reset = 1;
    repeat (20) @(negedge clock);
    check("rst_no_done", n_df + n_dl, 0);
    check("rst_idle", busy, 0);
    run_txn(1, 12'h2c4, 0, 0, BL);
    // Randomized traffic
    for (int n = 0; n < 20; n++) begin
      r = $urandom_range(0, 9);
      nb = r < 6 ? BL : r < 8 ? int'($urandom_range(1, BL - 1)) : 0;
      run_txn(1'($urandom), 12'($urandom), 1'($urandom), $urandom, nb);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
